inst_ram_loader: RTL and testbench

- Upstream feeder for the CPU instruction-RAM debug write port (inst_ram_write_enable/data/address, debug, reset).
- Consumes a byte stream (UART receiver or bench source) carrying a length header and program words.
- Packs the bytes into 32-bit words and writes them sequentially from PC_INITIAL.
- Holds the CPU in reset with debug high during the load, then releases it, so hand-written per-word load sequencing is no longer needed.

---
 rtl/inst_ram_loader_pkg.sv | 8 +
 rtl/inst_ram_loader_byte_packer.sv | 25 ++
 rtl/inst_ram_loader.sv | 92 +++++++++
 tb/tb_inst_ram_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_ram_loader_pkg.sv
// inst_ram_loader_pkg: shared FSM encoding and default load address
package inst_ram_loader_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [31:0] PC_INITIAL_DEF = 32'hbfc00000;
endpackage

// File: rtl/inst_ram_loader_byte_packer.sv
// inst_ram_loader_byte_packer: packs accepted bytes big-endian into 32-bit words
module inst_ram_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        fire,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  idx;
  logic [23:0] acc;
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      idx <= 2'd0;
      acc <= 24'd0;
    end else if (fire) begin
      idx <= idx + 2'd1;
      acc <= {acc[15:0], data};
    end
  end
  // the word completes combinationally with its 4th byte
  assign word_valid = fire && idx == 2'd3;
  assign word = {acc, data};
endmodule

// File: rtl/inst_ram_loader.sv
// inst_ram_loader: loads a length-prefixed byte stream into instruction RAM
// while holding the CPU in debug/reset, then releases it.
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter logic [31:0] PC_INITIAL = PC_INITIAL_DEF,
  parameter int          MAX_WORDS  = 1024,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             inst_ram_write_enable,
  output logic [31:0]      inst_ram_write_data,
  output logic [31:0]      inst_ram_write_address,
  output logic             debug,
  output logic             cpu_reset,
  output logic             load_done,
  output logic             load_error,
  output logic [CNT_W-1:0] words_written
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_WORDS);
  logic [1:0]       state;
  logic [CNT_W-1:0] len, eff_len, idx, hdr;
  logic             word_valid, go;
  logic [31:0]      word;
  assign in_ready = state == S_HDR || state == S_DATA;
  assign go = start && (state == S_IDLE || state == S_DONE);
  assign hdr = CNT_W'(word);
  inst_ram_loader_byte_packer packer (
    .clk(clk), .reset(reset), .clear(go), .fire(in_valid && in_ready),
    .data(in_data), .word_valid(word_valid), .word(word)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      len <= '0;
      eff_len <= '0;
      idx <= '0;
      inst_ram_write_enable <= 1'b0;
      inst_ram_write_data <= 32'd0;
      inst_ram_write_address <= PC_INITIAL;
      debug <= 1'b1;
      cpu_reset <= 1'b0;
      load_done <= 1'b0;
      load_error <= 1'b0;
      words_written <= '0;
    end else begin
      inst_ram_write_enable <= 1'b0;
      if (go) begin
        state <= S_HDR;
        idx <= '0;
        words_written <= '0;
        load_done <= 1'b0;
        load_error <= 1'b0;
        inst_ram_write_address <= PC_INITIAL;
        debug <= 1'b1;
        cpu_reset <= 1'b0;
      end else begin
        case (state)
          S_HDR: if (word_valid) begin
            len <= hdr;
            idx <= '0;
            state <= hdr == '0 ? S_DONE : S_DATA;
            load_error <= hdr > MAX;
            eff_len <= hdr > MAX ? MAX : hdr;
          end
          S_DATA: if (word_valid) begin
            idx <= idx + 1'b1;
            // words past eff_len are drained from the stream without a strobe
            if (idx < eff_len) begin
              inst_ram_write_enable <= 1'b1;
              inst_ram_write_data <= word;
              inst_ram_write_address <= PC_INITIAL + (32'(idx) << 2);
              words_written <= words_written + 1'b1;
            end
            if (idx + 1'b1 == len) state <= S_DONE;
          end
          S_DONE: begin
            debug <= 1'b0;
            cpu_reset <= 1'b1;
            load_done <= !load_error;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inst_ram_loader.sv
// tb_inst_ram_loader: scoreboard bench for the instruction RAM loader
module tb_inst_ram_loader;
  logic clk = 0, reset = 0, start_a = 0, start_b = 0, in_valid = 0;
  logic [7:0] in_data = 0;
  logic rdy_a, we_a, dbg_a, crst_a, done_a, err_a;
  logic rdy_b, we_b, dbg_b, crst_b, done_b, err_b;
  logic [31:0] wd_a, wa_a, ww_a, wd_b, wa_b, ww_b;
  logic sel = 0;
  logic m_rdy, m_we, m_dbg, m_crst, m_done, m_err;
  logic [31:0] m_wd, m_wa, m_ww;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] a; logic [31:0] d; int c;} exp_t;
  exp_t sb[$];
  logic [31:0] prog[$];

  inst_ram_loader dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_a), .inst_ram_write_enable(we_a), .inst_ram_write_data(wd_a),
    .inst_ram_write_address(wa_a), .debug(dbg_a), .cpu_reset(crst_a),
    .load_done(done_a), .load_error(err_a), .words_written(ww_a)
  );
  inst_ram_loader #(.MAX_WORDS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_b), .inst_ram_write_enable(we_b), .inst_ram_write_data(wd_b),
    .inst_ram_write_address(wa_b), .debug(dbg_b), .cpu_reset(crst_b),
    .load_done(done_b), .load_error(err_b), .words_written(ww_b)
  );

  assign m_rdy = sel ? rdy_b : rdy_a;
  assign m_we = sel ? we_b : we_a;
  assign m_dbg = sel ? dbg_b : dbg_a;
  assign m_crst = sel ? crst_b : crst_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err = sel ? err_b : err_a;
  assign m_wd = sel ? wd_b : wd_a;
  assign m_wa = sel ? wa_b : wa_a;
  assign m_ww = sel ? ww_b : ww_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) if (m_we) begin
    if (sb.size() == 0) check("sb_depth_at_strobe", 32'(sb.size()), 1);
    else begin
      e = sb.pop_front();
      check("wr_addr", m_wa, e.a);
      check("wr_data", m_wd, e.d);
      check("wr_cycle", cyc, e.c);
    end
  end

  task automatic send_byte(logic [7:0] b, bit push, logic [31:0] addr, logic [31:0] dat);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = b;
    while (!m_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_rdy) check("ready_timeout", m_rdy, 1);
    if (push) sb.push_back('{a: addr, d: dat, c: cyc + 1});
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic send_word(logic [31:0] w, bit gap, bit push, logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[31-8*i -: 8], push && i == 3, addr, w);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic run_load(logic [31:0] len, int maxw, bit gap);
    send_word(len, gap, 0, 0);
    for (int i = 0; i < prog.size(); i++)
      send_word(prog[i], gap, i < maxw, 32'hbfc00000 + 32'(4 * i));
  endtask

  task automatic pulse(bit b);
    @(negedge clk);
    if (b) start_b = 1; else start_a = 1;
    @(negedge clk);
    start_a = 0;
    start_b = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (m_crst !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_ready"}, m_rdy, 0);
    check({tag, "_we"}, m_we, 0);
    check({tag, "_wdata"}, m_wd, 0);
    check({tag, "_waddr"}, m_wa, 32'hbfc00000);
    check({tag, "_debug"}, m_dbg, 1);
    check({tag, "_cpu_reset"}, m_crst, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_error"}, m_err, 0);
    check({tag, "_words"}, m_ww, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1;
    // three-word load, back-to-back bytes
    pulse(0);
    prog = '{32'h200FFAF4, 32'h3C180123, 32'h01F87820};
    run_load(3, 1024, 0);
    wait_done();
    check("l3_debug", m_dbg, 0);
    check("l3_cpu_reset", m_crst, 1);
    check("l3_done", m_done, 1);
    check("l3_error", m_err, 0);
    check("l3_words", m_ww, 3);
    check("l3_ready", m_rdy, 0);
    // restart from DONE
    pulse(0);
    check("rs_debug", m_dbg, 1);
    check("rs_cpu_reset", m_crst, 0);
    check("rs_done", m_done, 0);
    check("rs_addr", m_wa, 32'hbfc00000);
    check("rs_words", m_ww, 0);
    // zero-length header
    prog = {};
    run_load(0, 1024, 0);
    @(negedge clk);
    check("l0_ready", m_rdy, 0);
    @(negedge clk);
    check("l0_done", m_done, 1);
    check("l0_cpu_reset", m_crst, 1);
    check("l0_words", m_ww, 0);
    // toggled valid, with an ignored start mid-word
    pulse(0);
    send_word(2, 1, 0, 0);
    send_byte(8'hAF, 0, 0, 0);
    @(negedge clk);
    send_byte(8'h0F, 0, 0, 0);
    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    send_byte(8'h00, 0, 0, 0);
    @(negedge clk);
    send_byte(8'h04, 1, 32'hbfc00000, 32'hAF0F0004);
    @(negedge clk);
    send_word(32'h8F0B0004, 1, 1, 32'hbfc00004);
    wait_done();
    check("tg_words", m_ww, 2);
    check("tg_done", m_done, 1);
    // oversize header on the MAX_WORDS=2 instance
    sel = 1;
    pulse(1);
    prog = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_load(4, 2, 0);
    wait_done();
    check("ov_error", m_err, 1);
    check("ov_done", m_done, 0);
    check("ov_cpu_reset", m_crst, 1);
    check("ov_debug", m_dbg, 0);
    check("ov_words", m_ww, 2);
    check("ov_ready", m_rdy, 0);
    // reset in the middle of the second word
    sel = 0;
    pulse(0);
    send_word(2, 0, 0, 0);
    send_word(32'hCAFEBABE, 0, 1, 32'hbfc00000);
    send_byte(8'hDE, 0, 0, 0);
    send_byte(8'hAD, 0, 0, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_reset("mid");
    reset = 1;
    repeat (2) @(negedge clk);
    check("mid_we_after", m_we, 0);
    pulse(0);
    prog = '{32'h12345678};
    run_load(1, 1024, 0);
    wait_done();
    check("rl_words", m_ww, 1);
    check("rl_done", m_done, 1);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
